// File: rtl/branch_ctrl.sv
// Branch resolution controller: evaluates the EX-stage branch condition, registers a PC
// redirect and holds a squash window. Optional statistics counters under `BRANCH_STATS_EN`.
module branch_ctrl #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [1:0]      i_branch_op,
  input  logic            i_zero,
  input  logic            i_neg,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_stall,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush,
  output logic            o_busy,
  output logic            o_misalign,
  output logic [31:0]     o_cnt_branches,
  output logic [31:0]     o_cnt_taken,
  output logic [31:0]     o_cnt_squashed
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;
  logic              busy_q, busy_d;
  logic              misalign_q, misalign_d;
  logic              cond;
  logic              taken;
  logic              aligned;

  // Branch condition decode from the ALU flags
  always_comb begin
    cond = 1'b0;
    case (i_branch_op)
      2'b00:   cond = i_zero;
      2'b01:   cond = !i_zero;
      2'b10:   cond = i_neg & !i_zero;
      2'b11:   cond = !i_neg | i_zero;
      default: cond = 1'b0;
    endcase
  end

  assign taken   = i_valid & cond;
  assign aligned = (i_target[1:0] == 2'b00);

  // Next state and next registered outputs; a stall freezes everything
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    flush_d    = flush_q;
    busy_d     = busy_q;
    misalign_d = misalign_q;
    if (!i_stall) begin
      redirect_d = 1'b0;
      flush_d    = 1'b0;
      busy_d     = 1'b0;
      misalign_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (taken && aligned) begin
            state_d    = ST_REDIRECT;
            pc_d       = i_target;
            cnt_d      = FLUSH_INIT;
            redirect_d = 1'b1;
            flush_d    = 1'b1;
            busy_d     = 1'b1;
          end else begin
            misalign_d = taken;
          end
        end
        ST_REDIRECT, ST_FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
            cnt_d   = cnt_q - 4'd1;
            flush_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Control state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      pc_q       <= {XLEN{1'b0}};
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      busy_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      busy_q     <= busy_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_redirect    = redirect_q;
  assign o_redirect_pc = pc_q;
  assign o_flush       = flush_q;
  assign o_busy        = busy_q;
  assign o_misalign    = misalign_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] cnt_br_q, cnt_br_d;
  logic [31:0] cnt_tk_q, cnt_tk_d;
  logic [31:0] cnt_sq_q, cnt_sq_d;
  logic        inc_br, inc_tk, inc_sq;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Statistics increments, qualified by stall and current state
  always_comb begin
    inc_br   = !i_stall && (state_q == ST_IDLE) && i_valid;
    inc_tk   = inc_br && taken && aligned;
    inc_sq   = !i_stall && (state_q != ST_IDLE) && i_valid;
    cnt_br_d = sat_inc(cnt_br_q, inc_br);
    cnt_tk_d = sat_inc(cnt_tk_q, inc_tk);
    cnt_sq_d = sat_inc(cnt_sq_q, inc_sq);
  end

  // Statistics counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_br_q <= 32'd0;
      cnt_tk_q <= 32'd0;
      cnt_sq_q <= 32'd0;
    end else begin
      cnt_br_q <= cnt_br_d;
      cnt_tk_q <= cnt_tk_d;
      cnt_sq_q <= cnt_sq_d;
    end
  end

  assign o_cnt_branches = cnt_br_q;
  assign o_cnt_taken    = cnt_tk_q;
  assign o_cnt_squashed = cnt_sq_q;
`else
  assign o_cnt_branches = 32'd0;
  assign o_cnt_taken    = 32'd0;
  assign o_cnt_squashed = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a behavioural model pushes the expected registered
// outputs per driven cycle; each scenario task pops and compares after the clock edge.
module tb_branch_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst, valid, zero, neg, stall;
  logic [1:0]  op;
  logic [31:0] target;
  logic        redirect, flush, busy, misalign;
  logic [31:0] redirect_pc, cnt_b, cnt_t, cnt_s;

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic        zero;
    logic        neg;
    logic [31:0] target;
    logic        stall;
    logic        rst;
  } stim_t;

  typedef struct packed {
    logic        redirect;
    logic [31:0] pc;
    logic        flush;
    logic        busy;
    logic        misalign;
    logic [31:0] cb;
    logic [31:0] ct;
    logic [31:0] cs;
  } out_t;

  out_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          m_rem = 0;
  logic        m_redir = 1'b0, m_mis = 1'b0;
  logic [31:0] m_pc = 32'd0, m_cb = 32'd0, m_ct = 32'd0, m_cs = 32'd0;

  branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_branch_op(op),
    .i_zero(zero), .i_neg(neg), .i_target(target), .i_stall(stall),
    .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_flush(flush),
    .o_busy(busy), .o_misalign(misalign), .o_cnt_branches(cnt_b),
    .o_cnt_taken(cnt_t), .o_cnt_squashed(cnt_s)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic [1:0] o, input logic z,
                               input logic n, input logic [31:0] t,
                               input logic s, input logic r);
    stim_t x;
    x.valid = v; x.op = o; x.zero = z; x.neg = n; x.target = t; x.stall = s; x.rst = r;
    return x;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic out_t dut_out();
    return {redirect, redirect_pc, flush, busy, misalign, cnt_b, cnt_t, cnt_s};
  endfunction

  task automatic model_step(input stim_t s);
    out_t e;
    logic lt, take;
    lt = s.neg && !s.zero;
    case (s.op)
      2'b00:   take = s.zero;
      2'b01:   take = !s.zero;
      2'b10:   take = lt;
      default: take = !lt;
    endcase
    take = take && s.valid;
    if (s.rst) begin
      m_rem = 0; m_redir = 1'b0; m_mis = 1'b0; m_pc = 32'd0;
      m_cb = 32'd0; m_ct = 32'd0; m_cs = 32'd0;
    end else if (!s.stall) begin
      if (m_rem == 0) begin
        m_redir = 1'b0;
        m_mis   = 1'b0;
        if (s.valid) m_cb = sat(m_cb);
        if (take && s.target[1:0] == 2'b00) begin
          m_rem = FC; m_redir = 1'b1; m_pc = s.target; m_ct = sat(m_ct);
        end else if (take) begin
          m_mis = 1'b1;
        end
      end else begin
        m_rem   = m_rem - 1;
        m_redir = 1'b0;
        m_mis   = 1'b0;
        if (s.valid) m_cs = sat(m_cs);
      end
    end
    e.redirect = m_redir;
    e.pc       = m_pc;
    e.flush    = (m_rem != 0);
    e.busy     = (m_rem != 0);
    e.misalign = m_mis;
`ifdef BRANCH_STATS_EN
    e.cb = m_cb; e.ct = m_ct; e.cs = m_cs;
`else
    e.cb = 32'd0; e.ct = 32'd0; e.cs = 32'd0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic drive(input stim_t s);
    valid = s.valid; op = s.op; zero = s.zero; neg = s.neg;
    target = s.target; stall = s.stall; rst = s.rst;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t exp, act;
    for (int i = 0; i < 2; i++) begin
      drive(mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h40, 1'b0, 1'b1));
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL reset[%0d] got %h want %h", i, act, exp); end
    end
  endtask

  task automatic test_taken();
    stim_t st[5];
    out_t exp, act;
    int nflush = 0;
    st[0] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h0000_0040, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) st[i] = idle();
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL taken[%0d] got %h want %h", i, act, exp); end
      if (act.flush === 1'b1) nflush++;
    end
    checks++;
    if (nflush != FC) begin errors++; $display("FAIL taken_flush_len got %0d want %0d", nflush, FC); end
  endtask

  task automatic test_not_taken();
    stim_t st[5];
    out_t exp, act;
    int nhit = 0;
    st[0] = mk(1'b1, 2'b01, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
    st[1] = mk(1'b1, 2'b10, 1'b0, 1'b0, 32'h104, 1'b0, 1'b0);
    st[2] = mk(1'b1, 2'b11, 1'b0, 1'b1, 32'h108, 1'b0, 1'b0);
    st[3] = mk(1'b1, 2'b00, 1'b0, 1'b0, 32'h10C, 1'b0, 1'b0);
    st[4] = idle();
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL not_taken[%0d] got %h want %h", i, act, exp); end
      if (act.redirect !== 1'b0 || act.flush !== 1'b0) nhit++;
    end
    checks++;
    if (nhit != 0) begin errors++; $display("FAIL not_taken_quiet got %0d want 0", nhit); end
  endtask

  task automatic test_squash();
    stim_t st[5];
    out_t exp, act;
    int nred = 0;
    st[0] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
    st[1] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0);
    st[2] = mk(1'b1, 2'b01, 1'b0, 1'b0, 32'h304, 1'b0, 1'b0);
    st[3] = idle();
    st[4] = idle();
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL squash[%0d] got %h want %h", i, act, exp); end
      if (act.redirect === 1'b1) nred++;
    end
    checks++;
    if (nred != 1) begin errors++; $display("FAIL squash_redirects got %0d want 1", nred); end
  endtask

  task automatic test_stall();
    stim_t st[8];
    out_t exp, act;
    int nred = 0, nflush = 0;
    st[0] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h400, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) st[i] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h500, 1'b1, 1'b0);
    for (int i = 4; i < 8; i++) st[i] = idle();
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL stall[%0d] got %h want %h", i, act, exp); end
      if (act.redirect === 1'b1) nred++;
      if (act.flush === 1'b1) nflush++;
    end
    checks++;
    if (nred != 4 || nflush != FC + 3) begin
      errors++; $display("FAIL stall_len got red=%0d flush=%0d want red=4 flush=%0d", nred, nflush, FC + 3);
    end
  endtask

  task automatic test_misalign();
    stim_t st[3];
    out_t exp, act;
    st[0] = mk(1'b1, 2'b11, 1'b0, 1'b0, 32'h0000_0042, 1'b0, 1'b0);
    st[1] = idle();
    st[2] = idle();
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL misalign[%0d] got %h want %h", i, act, exp); end
    end
  endtask

  task automatic test_reset_in_flush();
    stim_t st[4];
    out_t exp, act;
    st[0] = mk(1'b1, 2'b10, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0);
    st[1] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h700, 1'b0, 1'b0);
    st[2] = mk(1'b1, 2'b00, 1'b1, 1'b0, 32'h800, 1'b1, 1'b1);
    st[3] = idle();
    for (int i = 0; i < 4; i++) begin
      drive(st[i]);
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL rst_flush[%0d] got %h want %h", i, act, exp); end
    end
  endtask

  task automatic test_back_to_back();
    out_t exp, act;
    for (int i = 0; i < 8; i++) begin
      drive(mk(1'b1, 2'b11, 1'b1, 1'b1, 32'h1000 + 32'(i) * 32'd4, 1'b0, 1'b0));
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL back_to_back[%0d] got %h want %h", i, act, exp); end
    end
  endtask

  task automatic test_random();
    out_t exp, act;
    stim_t s;
    for (int i = 0; i < 300; i++) begin
      s = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 60) == 0));
      drive(s);
      exp = sb_q.pop_front(); act = dut_out(); checks++;
      if (act !== exp) begin errors++; $display("FAIL random[%0d] got %h want %h", i, act, exp); end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; op = 2'b00; zero = 1'b0; neg = 1'b0;
    target = 32'd0; stall = 1'b0;
    test_reset();
    test_taken();
    test_not_taken();
    test_squash();
    test_stall();
    test_misalign();
    test_reset_in_flush();
    test_back_to_back();
    test_random();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequencing controller for the branch resolution path of the pipelined core. Each cycle it takes the branch-class flag, the 2-bit branch condition code and the ALU `zero`/`neg` flags of the instruction in EX. It decides the branch outcome and registers a PC redirect. It then runs a flush sequence that squashes wrong-path instructions in IF/ID and ID/EX. The front end predicts not-taken, so only taken branches cost cycles.

## Interface
Parameters:
- `XLEN`, 32, PC/target width.
- `FLUSH_CYCLES`, 2, number of cycles `o_flush` is held per taken branch (legal range 1..15).

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_valid`  in  1  branch-class instruction present in EX this cycle.
- `i_branch_op`  in  2  condition: 00 eq, 01 ne, 10 lt, 11 ge.
- `i_zero`  in  1  ALU result == 0.
- `i_neg`  in  1  ALU result negative.
- `i_target`  in  XLEN  computed branch target.
- `i_stall`  in  1  global pipeline stall; freezes the block.
- `o_redirect`  out  1  one-cycle PC redirect strobe.
- `o_redirect_pc`  out  XLEN  registered target, valid while `o_redirect`=1.
- `o_flush`  out  1  squash IF/ID and ID/EX contents.
- `o_busy`  out  1  FSM not in IDLE.
- `o_misalign`  out  1  one-cycle strobe: taken branch to target with `[1:0]`≠0.
- `o_cnt_branches`, `o_cnt_taken`, `o_cnt_squashed`  out  32 each  statistics (see Configuration).

## Operation
Condition evaluation (combinational):
- `eq` = `i_zero`.
- `ne` = !`i_zero`.
- `lt` = `i_neg` & !`i_zero`.
- `ge` = !`i_neg` | `i_zero`.
- `taken` = `i_valid` & cond(`i_branch_op`).

States:
- IDLE: samples `i_valid`.
  - If `taken` and `i_target[1:0]`==0 → REDIRECT; latch `i_target`; load the flush counter with `FLUSH_CYCLES`-1.
  - If `taken` and misaligned → IDLE; `o_misalign`=1 next cycle; no redirect, no flush.
  - Otherwise stay in IDLE.
- REDIRECT (1 cycle): `o_redirect`=1, `o_flush`=1.
  - Counter==0 → IDLE.
  - Otherwise → FLUSH.
- FLUSH: `o_flush`=1; counter decrements each unstalled cycle. Counter reaches 0 → IDLE.

Rules:
- `i_valid` in REDIRECT/FLUSH is wrong-path: ignored for decision, counted as squashed.
- `i_stall`=1: state, counter, latched target, counters and all outputs hold their values. `i_valid` is not sampled.
- `i_rst` has priority over `i_stall`. Reset during REDIRECT/FLUSH returns to IDLE on the next edge with all outputs 0.
- All outputs are registered.
- Reset values: `o_redirect`=0, `o_redirect_pc`=0, `o_flush`=0, `o_busy`=0, `o_misalign`=0, counters=0.

## Timing
- Taken branch sampled at edge E.
  - `o_redirect` and `o_flush` are high during the cycle after E.
  - `o_flush` stays high for exactly `FLUSH_CYCLES` unstalled cycles.
  - The next branch is accepted on the first IDLE cycle.
- Not-taken branch: zero penalty; back-to-back not-taken branches accepted every cycle.
- `FLUSH_CYCLES`=1: REDIRECT → IDLE directly. The following cycle can accept a new branch.
- Stall cycles extend REDIRECT/FLUSH one-for-one. `o_redirect` remains high across a stall in REDIRECT; the fetch unit qualifies it with `!i_stall`.
- Misaligned taken branch: `o_misalign` is high for one cycle after E; `o_busy` stays 0.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `o_cnt_branches` counts accepted `i_valid` in IDLE.
  - `o_cnt_taken` counts taken, aligned branches.
  - `o_cnt_squashed` counts `i_valid` cycles in REDIRECT/FLUSH.
  - All counters are 32-bit, saturate at 0xFFFFFFFF, and hold under stall.
- Not defined: the three counter outputs are tied to 0 and no counter flops are synthesized. Ports remain.

## Test plan
- Reset, then `i_valid`=1, op=00, zero=1, target=0x0000_0040 → next cycle `o_redirect`=1, `o_redirect_pc`=0x40; `o_flush` high 2 cycles; `o_busy` low on 3rd cycle.
- Four consecutive not-taken branches (op=01, zero=1; op=10, neg=0; op=11, neg=1 zero=0; op=00, zero=0) → `o_redirect`/`o_flush` never assert. With `BRANCH_STATS_EN`: branches=4, taken=0.
- Taken branch with `i_valid`=1 during both flush cycles → no second redirect. With stats: branches=1, taken=1, squashed=2.
- Taken branch, `i_stall`=1 for 3 cycles during REDIRECT → `o_redirect` held for 4 cycles, `o_flush` total 5 cycles, `o_redirect_pc` unchanged.
- op=11, zero=0, neg=0, target=0x0000_0042 → `o_misalign`=1 for one cycle; `o_redirect`=0, `o_flush`=0.
- `i_rst`=1 asserted together with `i_stall`=1 in FLUSH → next cycle: IDLE, all outputs 0, counters 0.
